// File: rtl/dcache_access_nway.sv
// dcache_access_nway
//   N-way set-associative data cache access logic. Compares the tags of the
//   indexed set against the processor (or snoop) address, reports hit/miss,
//   selects the replacement victim, keeps per-set replacement state and runs
//   a three-state snoop FSM that borrows the array read port for two cycles.
//
//   Optional feature macro: DCACHE_LRU_EN
//     defined   -> per-set true-LRU age counters
//     undefined -> per-set round-robin pointer advanced on fill_done only
//
//   Ports
//     CLK, RST               clock (rising edge), async active-high reset
//     dmemREN/dmemWEN        processor read / write request
//     dmemaddr               processor byte address {tag, idx, offset, 2'b00}
//     halt                   suppresses miss reporting
//     tag_rd/valid_rd/dirty_rd/data_rd
//                            contents of the indexed set, way0 in the LSBs
//     fill_done              controller installed a block into victimway
//     snoop/snoopaddr/ccinv  coherence snoop request, address, invalidate
//     idx_sel                1: arrays indexed by snoopaddr, 0: by dmemaddr
//     hit/miss/hitway        processor hit/miss, hit way (processor or snoop)
//     victimway              replacement way for the indexed set
//     WENcache/newValid/newDirty
//                            array write strobe and the bits written to hitway
//     data_out               read data of hitway at the word offset
//     cctrans/ccwrite        snoop response valid / snoop hit a dirty line
//
//   Handshake: requests are levels. A processor request completes in the cycle
//   hit is high; while the snoop FSM is busy, hit and miss stay low and the
//   processor must hold its request.
module dcache_access_nway #(
   parameter int WAYS  = 2,
   parameter int SETS  = 8,
   parameter int WORDS = 2
) (
   input  logic                                                  CLK,
   input  logic                                                  RST,
   input  logic                                                  dmemREN,
   input  logic                                                  dmemWEN,
   input  logic [31:0]                                           dmemaddr,
   input  logic                                                  halt,
   input  logic [WAYS*(30-$clog2(SETS)-$clog2(WORDS))-1:0]      tag_rd,
   input  logic [WAYS-1:0]                                       valid_rd,
   input  logic [WAYS-1:0]                                       dirty_rd,
   input  logic [WAYS*WORDS*32-1:0]                              data_rd,
   input  logic                                                  fill_done,
   input  logic                                                  snoop,
   input  logic [31:0]                                           snoopaddr,
   input  logic                                                  ccinv,
   output logic                                                  idx_sel,
   output logic                                                  hit,
   output logic                                                  miss,
   output logic [$clog2(WAYS)-1:0]                               hitway,
   output logic [$clog2(WAYS)-1:0]                               victimway,
   output logic                                                  WENcache,
   output logic                                                  newValid,
   output logic                                                  newDirty,
   output logic [31:0]                                           data_out,
   output logic                                                  cctrans,
   output logic                                                  ccwrite
);

   localparam int IDXW = $clog2(SETS);
   localparam int OFFW = $clog2(WORDS);
   localparam int TAGW = 30 - IDXW - OFFW;
   localparam int WAYW = $clog2(WAYS);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;

   state_t          state, state_next;
   logic            shit, sdirty;
   logic [WAYW-1:0] sway;

   // Address fields
   logic [TAGW-1:0] d_tag, s_tag, cmp_tag;
   logic [IDXW-1:0] d_idx, s_idx, cur_idx;
   logic [OFFW-1:0] d_off;
   logic            unused_bits;

   assign d_tag   = dmemaddr[31 -: TAGW];
   assign s_tag   = snoopaddr[31 -: TAGW];
   assign d_idx   = dmemaddr[2+OFFW +: IDXW];
   assign s_idx   = snoopaddr[2+OFFW +: IDXW];
   assign d_off   = dmemaddr[2 +: OFFW];
   assign unused_bits = ^{dmemaddr[1:0], snoopaddr[OFFW+1:0]};

   // Any non-idle state owns the array read port.
   assign idx_sel = (state != S_IDLE);
   assign cmp_tag = idx_sel ? s_tag : d_tag;
   assign cur_idx = idx_sel ? s_idx : d_idx;

   // Tag compare; descending scan so the lowest matching way wins.
   logic            any_hit;
   logic [WAYW-1:0] hit_idx;

   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (valid_rd[w] && (tag_rd[w*TAGW +: TAGW] == cmp_tag)) begin
            any_hit = 1'b1;
            hit_idx = WAYW'(w);
         end
      end
   end

   logic req, proc_hit;
   assign req      = dmemREN | dmemWEN;
   assign proc_hit = (state == S_IDLE) && req && any_hit;

   // Replacement state
   logic [WAYW-1:0] repl_choice;

`ifdef DCACHE_LRU_EN
   // age 0 = most recently used, age WAYS-1 = least recently used.
   logic [WAYW-1:0] age [SETS][WAYS];
   logic            touch_en;
   logic [WAYW-1:0] touch_way;

   assign touch_en  = proc_hit | fill_done;
   assign touch_way = proc_hit ? hit_idx : victimway;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               age[s][w] <= WAYW'(w);
      end else if (touch_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAYW'(w) == touch_way)
               age[d_idx][w] <= '0;
            else if (age[d_idx][w] < age[d_idx][touch_way])
               age[d_idx][w] <= age[d_idx][w] + WAYW'(1);
         end
      end
   end

   always_comb begin
      repl_choice = '0;
      for (int w = 0; w < WAYS; w++)
         if (age[cur_idx][w] == WAYW'(WAYS-1))
            repl_choice = WAYW'(w);
   end
`else
   // Pointer wraps naturally because WAYS is a power of two.
   logic [WAYW-1:0] rr_ptr [SETS];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int s = 0; s < SETS; s++)
            rr_ptr[s] <= '0;
      end else if (fill_done) begin
         rr_ptr[d_idx] <= rr_ptr[d_idx] + WAYW'(1);
      end
   end

   assign repl_choice = rr_ptr[cur_idx];
`endif

   // Victim: first invalid way, otherwise the replacement choice.
   always_comb begin
      victimway = repl_choice;
      for (int w = WAYS-1; w >= 0; w--)
         if (!valid_rd[w])
            victimway = WAYW'(w);
   end

   // Snoop FSM: state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= state_next;
   end

   // Snoop FSM: next state. RESP always returns to IDLE so a held snoop
   // leaves the processor one IDLE cycle between snoops.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (snoop) state_next = S_LOOKUP;
         S_LOOKUP: state_next = S_RESP;
         S_RESP:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Snoop lookup result captured at the end of LOOKUP.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shit   <= 1'b0;
         sway   <= '0;
         sdirty <= 1'b0;
      end else if (state == S_LOOKUP) begin
         shit   <= any_hit;
         sway   <= hit_idx;
         sdirty <= dirty_rd[hit_idx];
      end
   end

   // Snoop FSM: outputs
   always_comb begin
      hit      = 1'b0;
      miss     = 1'b0;
      hitway   = '0;
      WENcache = 1'b0;
      newValid = 1'b0;
      newDirty = 1'b0;
      data_out = '0;
      cctrans  = 1'b0;
      ccwrite  = 1'b0;
      case (state)
         S_IDLE: begin
            hit  = proc_hit;
            miss = req && !any_hit && !halt;
            if (proc_hit) begin
               hitway   = hit_idx;
               data_out = data_rd[(int'(hit_idx)*WORDS + int'(d_off))*32 +: 32];
               if (dmemWEN) begin
                  WENcache = 1'b1;
                  newValid = 1'b1;
                  newDirty = 1'b1;
               end
            end
         end
         S_RESP: begin
            cctrans  = 1'b1;
            ccwrite  = shit & sdirty;
            hitway   = sway;
            WENcache = ccinv & shit;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dcache_access_nway.sv
// Testbench for dcache_access_nway (WAYS=4, SETS=8, WORDS=2). The bench owns
// the tag/valid/dirty/data arrays and a recency-list / pointer model of the
// replacement policy, and predicts every observed output from them.
module tb_dcache_access_nway;

   localparam int WAYS  = 4;
   localparam int SETS  = 8;
   localparam int WORDS = 2;
   localparam int IDXW  = 3;
   localparam int OFFW  = 1;
   localparam int TAGW  = 26;
   localparam int WAYW  = 2;

   logic                      CLK = 1'b0;
   logic                      RST;
   logic                      dmemREN, dmemWEN, halt, fill_done;
   logic [31:0]               dmemaddr, snoopaddr;
   logic                      snoop, ccinv;
   logic [WAYS*TAGW-1:0]      tag_rd;
   logic [WAYS-1:0]           valid_rd, dirty_rd;
   logic [WAYS*WORDS*32-1:0]  data_rd;
   logic                      idx_sel, hit, miss, WENcache, newValid, newDirty;
   logic                      cctrans, ccwrite;
   logic [WAYW-1:0]           hitway, victimway;
   logic [31:0]               data_out;

   int checks = 0;
   int errors = 0;

   dcache_access_nway #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
      .CLK(CLK), .RST(RST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .halt(halt), .tag_rd(tag_rd), .valid_rd(valid_rd),
      .dirty_rd(dirty_rd), .data_rd(data_rd), .fill_done(fill_done),
      .snoop(snoop), .snoopaddr(snoopaddr), .ccinv(ccinv), .idx_sel(idx_sel),
      .hit(hit), .miss(miss), .hitway(hitway), .victimway(victimway),
      .WENcache(WENcache), .newValid(newValid), .newDirty(newDirty),
      .data_out(data_out), .cctrans(cctrans), .ccwrite(ccwrite)
   );

   // Clock / reset
   always #5 CLK = ~CLK;

   // Cache arrays and replacement model
   logic [TAGW-1:0] m_tag   [SETS][WAYS];
   logic            m_valid [SETS][WAYS];
   logic            m_dirty [SETS][WAYS];
   logic [31:0]     m_data  [SETS][WAYS][WORDS];
`ifdef DCACHE_LRU_EN
   int order [SETS][WAYS];   // recency list, index 0 = most recent
`else
   int rr [SETS];
`endif
   logic [TAGW-1:0] tp [8];

   // Array read port, indexed as the DUT requests
   always_comb begin
      int s;
      s = idx_sel ? int'((snoopaddr >> (2+OFFW)) & (SETS-1))
                  : int'((dmemaddr  >> (2+OFFW)) & (SETS-1));
      tag_rd = '0; valid_rd = '0; dirty_rd = '0; data_rd = '0;
      for (int w = 0; w < WAYS; w++) begin
         tag_rd[w*TAGW +: TAGW] = m_tag[s][w];
         valid_rd[w] = m_valid[s][w];
         dirty_rd[w] = m_dirty[s][w];
         for (int k = 0; k < WORDS; k++)
            data_rd[(w*WORDS+k)*32 +: 32] = m_data[s][w][k];
      end
   end

   function automatic logic [31:0] mk(logic [TAGW-1:0] t, int s, int o);
      return (32'(t) << (2+OFFW+IDXW)) | (32'(s) << (2+OFFW)) | (32'(o) << 2);
   endfunction

   function automatic int set_of(logic [31:0] a);
      return int'((a >> (2+OFFW)) & (SETS-1));
   endfunction

   function automatic int off_of(logic [31:0] a);
      return int'((a >> 2) & (WORDS-1));
   endfunction

   function automatic logic [TAGW-1:0] tag_of(logic [31:0] a);
      logic [31:0] t;
      t = a >> (2+OFFW+IDXW);
      return t[TAGW-1:0];
   endfunction

   task automatic lookup(input int s, input logic [TAGW-1:0] t, output bit h, output int w);
      h = 0; w = 0;
      for (int i = 0; i < WAYS; i++)
         if (!h && m_valid[s][i] && m_tag[s][i] == t) begin
            h = 1; w = i;
         end
   endtask

   function automatic int victim(int s);
      for (int i = 0; i < WAYS; i++)
         if (!m_valid[s][i]) return i;
`ifdef DCACHE_LRU_EN
      return order[s][WAYS-1];
`else
      return rr[s];
`endif
   endfunction

`ifdef DCACHE_LRU_EN
   task automatic touch(input int s, input int w);
      int p = 0;
      for (int i = 0; i < WAYS; i++) if (order[s][i] == w) p = i;
      for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
      order[s][0] = w;
   endtask
`endif

   task automatic reset_repl();
      for (int s = 0; s < SETS; s++) begin
`ifdef DCACHE_LRU_EN
         for (int i = 0; i < WAYS; i++) order[s][i] = i;
`else
         rr[s] = 0;
`endif
      end
   endtask

   // Scoreboard comparison
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK); #1;
   endtask

   // One processor access; on a miss (without halt) the controller fills
   // the victim way in the same cycle.
   task automatic proc_access(input logic [31:0] a, input bit wr, input bit hlt);
      int s, w, v, o;
      bit h;
      s = set_of(a); o = off_of(a);
      lookup(s, tag_of(a), h, w);
      v = victim(s);
      dmemaddr = a; dmemREN = !wr; dmemWEN = wr; halt = hlt;
      @(negedge CLK);
      chk("hit", hit, h);
      chk("miss", miss, !h && !hlt);
      chk("victimway", victimway, v);
      chk("idx_sel_idle", idx_sel, 0);
      chk("cctrans_idle", cctrans, 0);
      chk("WENcache", WENcache, h && wr);
      if (h) chk("hitway", hitway, w);
      if (h && wr) begin
         chk("newValid", newValid, 1);
         chk("newDirty", newDirty, 1);
      end
      if (h && !wr) chk("data_out", data_out, m_data[s][w][o]);
      if (!h && !hlt) fill_done = 1;
      cyc();
      fill_done = 0; dmemREN = 0; dmemWEN = 0; halt = 0;
      if (h) begin
`ifdef DCACHE_LRU_EN
         touch(s, w);
`endif
         if (wr) m_dirty[s][w] = 1;
      end else if (!hlt) begin
         m_tag[s][v] = tag_of(a); m_valid[s][v] = 1; m_dirty[s][v] = 0;
         for (int k = 0; k < WORDS; k++) m_data[s][v][k] = $urandom;
`ifdef DCACHE_LRU_EN
         touch(s, v);
`else
         rr[s] = (rr[s] + 1) % WAYS;
`endif
      end
   endtask

   // One full snoop (IDLE, LOOKUP, RESP) with an optional processor read
   // presented from the IDLE cycle onward.
   task automatic do_snoop(input logic [31:0] sa, input bit inv, input bit with_proc,
                           input logic [31:0] pa);
      int ss, sw, ps, pw;
      bit sh, ph, sd;
      ps = set_of(pa);
      lookup(ps, tag_of(pa), ph, pw);
      snoop = 1; snoopaddr = sa; ccinv = inv; dmemaddr = pa; dmemREN = with_proc;
      @(negedge CLK);
      chk("snp_idle_idx_sel", idx_sel, 0);
      chk("snp_idle_cctrans", cctrans, 0);
      chk("snp_idle_hit", hit, with_proc && ph);
      chk("snp_idle_miss", miss, with_proc && !ph);
      if (with_proc && ph) chk("snp_idle_data", data_out, m_data[ps][pw][off_of(pa)]);
      cyc();
`ifdef DCACHE_LRU_EN
      if (with_proc && ph) touch(ps, pw);
`endif
      snoop = 0;
      ss = set_of(sa);
      lookup(ss, tag_of(sa), sh, sw);
      sd = sh && m_dirty[ss][sw];
      @(negedge CLK);
      chk("lookup_idx_sel", idx_sel, 1);
      chk("lookup_hit", hit, 0);
      chk("lookup_miss", miss, 0);
      chk("lookup_cctrans", cctrans, 0);
      chk("lookup_WENcache", WENcache, 0);
      cyc();
      @(negedge CLK);
      chk("resp_idx_sel", idx_sel, 1);
      chk("resp_cctrans", cctrans, 1);
      chk("resp_ccwrite", ccwrite, sd);
      chk("resp_WENcache", WENcache, inv && sh);
      chk("resp_hit", hit, 0);
      chk("resp_miss", miss, 0);
      if (sh) chk("resp_hitway", hitway, sw);
      if (inv && sh) begin
         chk("resp_newValid", newValid, 0);
         chk("resp_newDirty", newDirty, 0);
      end
      cyc();
      if (inv && sh) begin
         m_valid[ss][sw] = 0; m_dirty[ss][sw] = 0;
      end
      dmemREN = 0; ccinv = 0;
      @(negedge CLK);
      chk("post_idx_sel", idx_sel, 0);
      chk("post_cctrans", cctrans, 0);
      cyc();
   endtask

   initial begin
      bit h;
      int w;
      RST = 1; dmemREN = 0; dmemWEN = 0; halt = 0; fill_done = 0;
      dmemaddr = '0; snoopaddr = '0; snoop = 0; ccinv = 0;
      for (int s = 0; s < SETS; s++)
         for (int i = 0; i < WAYS; i++) begin
            m_tag[s][i] = '0; m_valid[s][i] = 0; m_dirty[s][i] = 0;
            for (int k = 0; k < WORDS; k++) m_data[s][i][k] = '0;
         end
      for (int i = 0; i < 8; i++) tp[i] = TAGW'(($urandom << 3) | i);
      reset_repl();

      // Reset state
      cyc(); cyc();
      @(negedge CLK);
      chk("rst_hit", hit, 0);
      chk("rst_miss", miss, 0);
      chk("rst_idx_sel", idx_sel, 0);
      chk("rst_WENcache", WENcache, 0);
      chk("rst_cctrans", cctrans, 0);
      chk("rst_ccwrite", ccwrite, 0);
      chk("rst_hitway", hitway, 0);
      chk("rst_victimway", victimway, 0);
      chk("rst_data_out", data_out, 0);
      cyc();
      RST = 0;

      // Set 3: fill all four ways, then read hit in way 2
      for (int i = 0; i < 4; i++) proc_access(mk(tp[i], 3, 0), 0, 0);
      proc_access(mk(tp[2], 3, 1), 0, 0);

      // Set 5: write hit way 1, strobe lasts one cycle
      proc_access(mk(tp[0], 5, 0), 0, 0);
      proc_access(mk(tp[1], 5, 0), 0, 0);
      proc_access(mk(tp[1], 5, 1), 1, 0);
      @(negedge CLK);
      chk("wen_one_cycle", WENcache, 0);
      cyc();

      // Set 2: touch 0,1,2,3 (fills) then 0
      for (int i = 0; i < 4; i++) proc_access(mk(tp[i], 2, 0), 0, 0);
      proc_access(mk(tp[0], 2, 0), 0, 0);
      dmemaddr = mk(tp[5], 2, 0);
      @(negedge CLK);
`ifdef DCACHE_LRU_EN
      chk("lru_victim_set2", victimway, 1);
`else
      chk("rr_victim_set2", victimway, 0);
`endif
      cyc();

      // Dirty way 3 of set 3, then invalidating snoop with a concurrent read hit
      proc_access(mk(tp[3], 3, 0), 1, 0);
      do_snoop(mk(tp[3], 3, 0), 1, 1, mk(tp[2], 3, 1));
      // Snoop miss
      do_snoop(mk(tp[7], 3, 0), 1, 0, '0);
      // Invalidated line now misses and is refilled
      lookup(3, tp[3], h, w);
      chk("inv_cleared", h, 0);
      proc_access(mk(tp[3], 3, 0), 0, 0);

      // Held snoop: one IDLE cycle between consecutive snoops
      snoop = 1; snoopaddr = mk(tp[0], 5, 0); ccinv = 0;
      cyc();
      @(negedge CLK); chk("fair_lookup1", idx_sel, 1);
      cyc();
      @(negedge CLK); chk("fair_resp1", cctrans, 1);
      cyc();
      @(negedge CLK); chk("fair_idle", idx_sel, 0); chk("fair_idle_cctrans", cctrans, 0);
      cyc();
      @(negedge CLK); chk("fair_lookup2", idx_sel, 1); snoop = 0;
      cyc();
      lookup(5, tp[0], h, w);
      @(negedge CLK); chk("fair_resp2", cctrans, 1);
      chk("fair_ccwrite", ccwrite, h && m_dirty[5][w]);
      cyc();

      // Reset asserted during LOOKUP
      dmemaddr = mk(tp[0], 3, 0);
      snoop = 1; snoopaddr = mk(tp[2], 3, 0); ccinv = 1;
      cyc();
      @(negedge CLK);
      chk("rst_mid_lookup", idx_sel, 1);
      RST = 1; snoop = 0; ccinv = 0;
      reset_repl();
      cyc();
      @(negedge CLK);
      chk("rstsnp_idx_sel", idx_sel, 0);
      chk("rstsnp_cctrans", cctrans, 0);
      chk("rstsnp_ccwrite", ccwrite, 0);
      chk("rstsnp_WENcache", WENcache, 0);
      chk("rstsnp_hit", hit, 0);
      chk("rstsnp_miss", miss, 0);
      chk("rstsnp_victimway", victimway, victim(3));
      cyc();
      RST = 0;
      @(negedge CLK);
      chk("rstsnp_after_cctrans", cctrans, 0);
      chk("rstsnp_after_WENcache", WENcache, 0);
      cyc();

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         int op;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         a = mk(tp[$urandom_range(0, 5)], $urandom_range(0, SETS-1), $urandom_range(0, WORDS-1));
         if (op <= 3)
            proc_access(a, 0, $urandom_range(0, 7) == 0);
         else if (op <= 6)
            proc_access(a, 1, $urandom_range(0, 7) == 0);
         else
            do_snoop(a, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                     mk(tp[$urandom_range(0, 5)], $urandom_range(0, SETS-1), $urandom_range(0, WORDS-1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
